sensor_scheduler: RTL and testbench

Time-shares the pet's sensor datapath inside one fixed frame.
- Each frame: fires the ultrasonic trigger pulse, times the echo, then requests one MPU6050 accelerometer read over the existing I2C reader via a start/done handshake.
- Publishes a distance measurement, a "near" flag and an MPU-read strobe to the pet FSM.
- Sits between TopBrain's sensor blocks (ultrasonic, mpu6050) and the FSM; replaces their free-running timing.

---
 rtl/sched_pkg.sv | 12 +
 rtl/echo_meter.sv | 46 ++++
 rtl/sensor_scheduler.sv | 136 +++++++++++++
 tb/tb_sensor_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// sched_pkg: state encoding, fault bit positions and default timing constants for sensor_scheduler
package sched_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, ECHO_WAIT, ECHO_MEAS, MPU_REQ, MPU_WAIT, GAP} state_e;
  localparam int FLT_ECHO = 0;
  localparam int FLT_MPU = 1;
  localparam int DEF_PERIOD_CYC = 3_000_000;
  localparam int DEF_TRIG_CYC = 500;
  localparam int DEF_ECHO_TIMEOUT_CYC = 1_200_000;
  localparam int DEF_ECHO_NEAR_CYC = 29_000;
  localparam int DEF_MPU_TIMEOUT_CYC = 100_000;
  localparam int DEF_CW = 22;
endpackage

// File: rtl/echo_meter.sv
// echo_meter: synchronises echo, detects its edges, times the pulse width and flags the echo timeout
module echo_meter
  import sched_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int TIMEOUT_CYC = DEF_ECHO_TIMEOUT_CYC
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          echo_i,
  input  logic          wait_i,
  input  logic          meas_i,
  output logic          rise_o,
  output logic          meas_done_o,
  output logic          timeout_o,
  output logic [CW-1:0] width_o
);
  logic meta_q, echo_s_q, echo_p_q;
  logic [CW-1:0] sc_q, sc_d, wc_q, wc_d;
  assign rise_o = wait_i & echo_s_q & ~echo_p_q;
  assign meas_done_o = meas_i & ~echo_s_q & echo_p_q;
  assign timeout_o = (wait_i | meas_i) && sc_q == CW'(TIMEOUT_CYC);
  assign width_o = wc_q;
  assign sc_d = (wait_i | meas_i) ? sc_q + 1'b1 : '0;
  assign wc_d = rise_o ? CW'(1) : (meas_i && wc_q != '1) ? wc_q + 1'b1 : wc_q;
  // two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      meta_q <= 1'b0;
      echo_s_q <= 1'b0;
      echo_p_q <= 1'b0;
    end else begin
      meta_q <= echo_i;
      echo_s_q <= meta_q;
      echo_p_q <= echo_s_q;
    end
  // timeout counter runs from trig fall; width counter saturates
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sc_q <= '0;
      wc_q <= '0;
    end else begin
      sc_q <= sc_d;
      wc_q <= wc_d;
    end
endmodule

// File: rtl/sensor_scheduler.sv
// sensor_scheduler: per-frame ultrasonic ranging then one MPU read; SCHED_NEAR_FILTER_EN debounces near over two frames
module sensor_scheduler
  import sched_pkg::*;
#(
  parameter int PERIOD_CYC = DEF_PERIOD_CYC,
  parameter int TRIG_CYC = DEF_TRIG_CYC,
  parameter int ECHO_TIMEOUT_CYC = DEF_ECHO_TIMEOUT_CYC,
  parameter int ECHO_NEAR_CYC = DEF_ECHO_NEAR_CYC,
  parameter int MPU_TIMEOUT_CYC = DEF_MPU_TIMEOUT_CYC,
  parameter int CW = DEF_CW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enable_i,
  input  logic          fast_i,
  input  logic          echo_i,
  output logic          trig_o,
  output logic          mpu_start_o,
  input  logic          mpu_done_i,
  output logic [CW-1:0] dist_cyc_o,
  output logic          dist_valid_o,
  output logic          near_o,
  output logic          mpu_valid_o,
  output logic [1:0]    fault_o,
  output logic          busy_o
);
  localparam logic [CW-1:0] LIM = CW'(PERIOD_CYC - 1);
  localparam logic [CW-1:0] LIM_F = CW'(PERIOD_CYC / 8 - 1);
  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYC - 1);
  localparam logic [CW-1:0] ECHO_TO = CW'(ECHO_TIMEOUT_CYC);
  localparam logic [CW-1:0] MPU_TO = CW'(MPU_TIMEOUT_CYC);
  localparam logic [CW-1:0] NEAR_TH = CW'(ECHO_NEAR_CYC);
  state_e state_q;
  logic [CW-1:0] fc_q, sc_q, dist_q, width;
  logic [1:0] fault_q;
  logic trig_q, start_q, dv_q, near_q, mv_q, fast_q, ovr_q;
  logic rise, meas_done, timeout, wrap, mpu_end, frame_end, start, near_raw, near_d;
  echo_meter #(.CW(CW), .TIMEOUT_CYC(ECHO_TIMEOUT_CYC)) u_echo (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .echo_i(echo_i),
    .wait_i(state_q == ECHO_WAIT),
    .meas_i(state_q == ECHO_MEAS),
    .rise_o(rise),
    .meas_done_o(meas_done),
    .timeout_o(timeout),
    .width_o(width)
  );
  assign wrap = fc_q == (fast_q ? LIM_F : LIM);
  assign mpu_end = state_q == MPU_WAIT && (mpu_done_i || sc_q == MPU_TO);
  assign frame_end = (wrap && (state_q == GAP || mpu_end)) || (mpu_end && ovr_q);
  assign start = enable_i && (state_q == IDLE || frame_end);
  assign near_raw = meas_done && width < NEAR_TH;
`ifdef SCHED_NEAR_FILTER_EN
  logic cand_q;
  // last raw verdict; near only moves once two consecutive frames agree
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cand_q <= 1'b0;
    else if (meas_done || timeout) cand_q <= near_raw;
  assign near_d = (near_raw == cand_q) ? near_raw : near_q;
`else
  assign near_d = near_raw;
`endif
  // frame sequencer with registered outputs; a late sequence skips GAP and starts the next frame directly
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      fc_q <= '0;
      sc_q <= '0;
      dist_q <= '0;
      fault_q <= '0;
      trig_q <= 1'b0;
      start_q <= 1'b0;
      dv_q <= 1'b0;
      near_q <= 1'b0;
      mv_q <= 1'b0;
      fast_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      mv_q <= 1'b0;
      start_q <= 1'b0;
      if (state_q != IDLE) begin
        fc_q <= wrap ? '0 : fc_q + 1'b1;
        if (wrap && state_q != GAP) ovr_q <= 1'b1;
      end
      case (state_q)
        TRIG:
          if (sc_q == TRIG_LAST) begin
            state_q <= ECHO_WAIT;
            trig_q <= 1'b0;
            sc_q <= '0;
          end else sc_q <= sc_q + 1'b1;
        ECHO_WAIT, ECHO_MEAS:
          if (meas_done || timeout) begin
            dist_q <= meas_done ? width : ECHO_TO;
            fault_q[FLT_ECHO] <= ~meas_done;
            near_q <= near_d;
            dv_q <= 1'b1;
            state_q <= MPU_REQ;
          end else if (rise) state_q <= ECHO_MEAS;
        MPU_REQ: begin
          start_q <= 1'b1;
          sc_q <= '0;
          state_q <= MPU_WAIT;
        end
        MPU_WAIT:
          if (mpu_end) begin
            mv_q <= mpu_done_i;
            fault_q[FLT_MPU] <= ~mpu_done_i;
            state_q <= GAP;
          end else sc_q <= sc_q + 1'b1;
        default: ;
      endcase
      if (start) begin
        state_q <= TRIG;
        trig_q <= 1'b1;
        sc_q <= '0;
        fc_q <= '0;
        fast_q <= fast_i;
        ovr_q <= 1'b0;
      end else if (frame_end) begin
        state_q <= IDLE;
        fc_q <= '0;
        ovr_q <= 1'b0;
      end
    end
  assign trig_o = trig_q;
  assign mpu_start_o = start_q;
  assign dist_cyc_o = dist_q;
  assign dist_valid_o = dv_q;
  assign near_o = near_q;
  assign mpu_valid_o = mv_q;
  assign fault_o = fault_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_sensor_scheduler.sv
// tb_sensor_scheduler: directed scenarios for sensor_scheduler with hand-computed expectations
module tb_sensor_scheduler;
  localparam int CW = 22;
  localparam int W_TRIG = 0, W_DV = 1, W_MS = 2, W_MV = 3, W_BUSY = 4, W_F1 = 5;
  logic clk = 0, rst_n = 0, enable = 0, fast = 0, echo = 0, mpu_done = 0;
  logic trig, mpu_start, dist_valid, near, mpu_valid, busy;
  logic [CW-1:0] dist_cyc;
  logic [1:0] fault;
  int checks = 0, failures = 0, cyc = 0, t_rise = 0;
  int dv_cnt = 0, mv_cnt = 0, overlap = 0, longs = 0;
  logic dv_p = 0, mv_p = 0, ms_p = 0;

  sensor_scheduler #(
    .PERIOD_CYC(2000), .TRIG_CYC(10), .ECHO_TIMEOUT_CYC(800),
    .ECHO_NEAR_CYC(300), .MPU_TIMEOUT_CYC(400), .CW(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .fast_i(fast), .echo_i(echo),
    .trig_o(trig), .mpu_start_o(mpu_start), .mpu_done_i(mpu_done),
    .dist_cyc_o(dist_cyc), .dist_valid_o(dist_valid), .near_o(near),
    .mpu_valid_o(mpu_valid), .fault_o(fault), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dist_valid) dv_cnt++;
    if (mpu_valid) mv_cnt++;
    if (dist_valid && mpu_valid) overlap++;
    if ((dist_valid && dv_p) || (mpu_valid && mv_p) || (mpu_start && ms_p)) longs++;
    dv_p = dist_valid;
    mv_p = mpu_valid;
    ms_p = mpu_start;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic sel(input int w);
    case (w)
      W_TRIG: return trig;
      W_DV: return dist_valid;
      W_MS: return mpu_start;
      W_MV: return mpu_valid;
      W_BUSY: return busy;
      default: return fault[1];
    endcase
  endfunction

  task automatic wait_for(input int w, input logic v, input int max, output int n);
    n = 0;
    while (sel(w) !== v && n < max) begin tick(); n++; end
    checks++;
    if (sel(w) !== v) begin
      failures++;
      $display("FAIL wait sig%0d got=%b required=%b within %0d cycles", w, sel(w), v, max);
    end
  endtask

  task automatic echo_pulse(input int dly, input int width);
    int n;
    wait_for(W_TRIG, 1'b0, 20, n);
    tick(dly);
    echo = 1;
    tick(width);
    echo = 0;
  endtask

  task automatic mpu_ack(input int dly);
    int n;
    wait_for(W_MS, 1'b1, 20, n);
    tick(dly);
    mpu_done = 1;
    tick();
    mpu_done = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    enable = 0;
    tick(3);
    checks++;
    if ({trig, mpu_start, dist_valid, near, mpu_valid, busy, fault, dist_cyc} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", {trig, mpu_start, dist_valid, near, mpu_valid, busy, fault, dist_cyc});
    end
    rst_n = 1;
    tick(5);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_disabled busy got=%b required=0", busy); end
  endtask

  task automatic test_near_echo;
    int n, w;
    enable = 1;
    wait_for(W_TRIG, 1'b1, 5, n);
    t_rise = cyc;
    w = 0;
    while (trig === 1'b1 && w < 50) begin tick(); w++; end
    checks++;
    if (w != 10) begin failures++; $display("FAIL t1_trig_width got=%0d required=10", w); end
    echo_pulse(50, 200);
    wait_for(W_DV, 1'b1, 10, n);
    checks++;
    if (dist_cyc < 198 || dist_cyc > 202) begin failures++; $display("FAIL t1_dist got=%0d required=200+-2", dist_cyc); end
    checks++;
    if (near !== 1'b1 || fault !== 2'b00) begin failures++; $display("FAIL t1_near_fault got=%b/%b required=1/00", near, fault); end
    checks++;
    if (mpu_start !== 1'b0) begin failures++; $display("FAIL t1_start_early got=%b required=0", mpu_start); end
    tick();
    checks++;
    if (dist_valid !== 1'b0 || mpu_start !== 1'b1) begin
      failures++;
      $display("FAIL t1_strobe_seq dv/start got=%b/%b required=0/1", dist_valid, mpu_start);
    end
    mpu_ack(10);
    checks++;
    if (mpu_valid !== 1'b1) begin failures++; $display("FAIL t1_mpu_valid got=%b required=1", mpu_valid); end
  endtask

  task automatic test_far_mpu;
    int n;
    wait_for(W_TRIG, 1'b1, 2100, n);
    checks++;
    if (cyc - t_rise != 2000) begin failures++; $display("FAIL t2_frame_len got=%0d required=2000", cyc - t_rise); end
    t_rise = cyc;
    echo_pulse(50, 500);
    wait_for(W_DV, 1'b1, 10, n);
    checks++;
    if (dist_cyc !== 22'd500 || near !== 1'b0) begin
      failures++;
      $display("FAIL t2_dist_near got=%0d/%b required=500/0", dist_cyc, near);
    end
    mpu_ack(30);
    checks++;
    if (mpu_valid !== 1'b1 || fault !== 2'b00) begin
      failures++;
      $display("FAIL t2_mpu got=%b/%b required=1/00", mpu_valid, fault);
    end
    tick();
    checks++;
    if (mpu_valid !== 1'b0) begin failures++; $display("FAIL t2_mpu_valid_width got=%b required=0", mpu_valid); end
  endtask

  task automatic test_echo_timeout;
    int n;
    wait_for(W_TRIG, 1'b1, 2100, n);
    t_rise = cyc;
    wait_for(W_TRIG, 1'b0, 20, n);
    wait_for(W_DV, 1'b1, 1000, n);
    checks++;
    if (n < 798 || n > 803) begin failures++; $display("FAIL t3_timeout_delay got=%0d required=800", n); end
    checks++;
    if (fault !== 2'b01 || dist_cyc !== 22'd800 || near !== 1'b0) begin
      failures++;
      $display("FAIL t3_timeout fault/dist/near got=%b/%0d/%b required=01/800/0", fault, dist_cyc, near);
    end
    tick();
    checks++;
    if (mpu_start !== 1'b1) begin failures++; $display("FAIL t3_mpu_after_timeout got=%b required=1", mpu_start); end
    mpu_ack(5);
    wait_for(W_TRIG, 1'b1, 2100, n);
    t_rise = cyc;
    echo_pulse(50, 100);
    wait_for(W_DV, 1'b1, 10, n);
    checks++;
    if (fault !== 2'b00 || dist_cyc !== 22'd100 || near !== 1'b1) begin
      failures++;
      $display("FAIL t3_recover fault/dist/near got=%b/%0d/%b required=00/100/1", fault, dist_cyc, near);
    end
    mpu_ack(5);
  endtask

  task automatic test_mpu_timeout;
    int n, mv0;
    wait_for(W_TRIG, 1'b1, 2100, n);
    t_rise = cyc;
    echo_pulse(50, 200);
    wait_for(W_DV, 1'b1, 10, n);
    wait_for(W_MS, 1'b1, 5, n);
    mv0 = mv_cnt;
    wait_for(W_F1, 1'b1, 500, n);
    checks++;
    if (n < 399 || n > 403) begin failures++; $display("FAIL t4_mpu_timeout_delay got=%0d required=400", n); end
    checks++;
    if (mv_cnt != mv0 || mpu_valid !== 1'b0) begin
      failures++;
      $display("FAIL t4_no_mpu_valid got=%0d pulses required=0", mv_cnt - mv0);
    end
    mpu_done = 1;
    tick();
    mpu_done = 0;
    tick(2);
    checks++;
    if (mv_cnt != mv0 || fault !== 2'b10) begin
      failures++;
      $display("FAIL t4_stray_done pulses/fault got=%0d/%b required=0/10", mv_cnt - mv0, fault);
    end
  endtask

  task automatic test_async_reset;
    int n, w;
    wait_for(W_TRIG, 1'b1, 2100, n);
    wait_for(W_TRIG, 1'b0, 20, n);
    tick(20);
    echo = 1;
    tick(50);
    rst_n = 0;
    #1;
    checks++;
    if ({trig, mpu_start, dist_valid, near, mpu_valid, busy, fault, dist_cyc} !== '0) begin
      failures++;
      $display("FAIL t5_async_reset got=%h required=0", {trig, mpu_start, dist_valid, near, mpu_valid, busy, fault, dist_cyc});
    end
    echo = 0;
    tick(3);
    checks++;
    if (busy !== 1'b0 || trig !== 1'b0) begin failures++; $display("FAIL t5_held_reset busy/trig got=%b/%b required=0/0", busy, trig); end
    rst_n = 1;
    wait_for(W_TRIG, 1'b1, 5, n);
    t_rise = cyc;
    w = 0;
    while (trig === 1'b1 && w < 50) begin tick(); w++; end
    checks++;
    if (w != 10) begin failures++; $display("FAIL t5_trig_width got=%0d required=10", w); end
    echo_pulse(30, 150);
    wait_for(W_DV, 1'b1, 10, n);
    checks++;
    if (dist_cyc !== 22'd150 || fault !== 2'b00 || near !== 1'b1) begin
      failures++;
      $display("FAIL t5_restart dist/fault/near got=%0d/%b/%b required=150/00/1", dist_cyc, fault, near);
    end
    mpu_ack(5);
  endtask

  task automatic test_fast_enable;
    int n;
    fast = 1;
    wait_for(W_TRIG, 1'b1, 2100, n);
    checks++;
    if (cyc - t_rise != 2000) begin failures++; $display("FAIL t6_slow_frame got=%0d required=2000", cyc - t_rise); end
    t_rise = cyc;
    echo_pulse(20, 30);
    wait_for(W_DV, 1'b1, 10, n);
    mpu_ack(5);
    wait_for(W_TRIG, 1'b1, 300, n);
    checks++;
    if (cyc - t_rise != 250) begin failures++; $display("FAIL t6_fast_frame got=%0d required=250", cyc - t_rise); end
    t_rise = cyc;
    enable = 0;
    echo_pulse(20, 30);
    wait_for(W_DV, 1'b1, 10, n);
    mpu_ack(5);
    checks++;
    if (mpu_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL t6_frame_completes mpu_valid/busy got=%b/%b required=1/1", mpu_valid, busy);
    end
    wait_for(W_BUSY, 1'b0, 300, n);
    checks++;
    if (cyc - t_rise != 250) begin failures++; $display("FAIL t6_idle_at_boundary got=%0d required=250", cyc - t_rise); end
    tick(20);
    checks++;
    if (busy !== 1'b0 || trig !== 1'b0) begin failures++; $display("FAIL t6_stay_idle busy/trig got=%b/%b required=0/0", busy, trig); end
  endtask

  task automatic test_strobes;
    checks++;
    if (overlap != 0 || longs != 0) begin
      failures++;
      $display("FAIL strobe_shape overlap/long got=%0d/%0d required=0/0", overlap, longs);
    end
    checks++;
    if (dv_cnt != 8 || mv_cnt != 7) begin
      failures++;
      $display("FAIL strobe_counts dv/mv got=%0d/%0d required=8/7", dv_cnt, mv_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_near_echo();
    test_far_mpu();
    test_echo_timeout();
    test_mpu_timeout();
    test_async_reset();
    test_fast_enable();
    test_strobes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
